run_detector: RTL and testbench
===============================

Name: run_detector

Overview:
- Parametrised successor to the fixed 4-sample binary-encoded sequence FSM.
- Detects a run of RUN_LEN consecutive equal samples on serial input w.
- Adds per-polarity mode select, hold/retrigger policy, a sample enable, and a saturating hit counter.
- Sits between the input synchroniser/debouncer and the board display logic; State, run_count and hits drive the LEDs and 7-seg.

Parameters:
- RUN_LEN, 4, number of consecutive equal samples constituting a hit; legal range 2..255.
- CNT_W, $clog2(RUN_LEN+1), width of run_count.
- HIT_W, 8, width of the hits counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; w is consumed only on edges where en=1.
- w  input  1  serial sample.
- mode  input  2  00 detect both polarities, 01 ones only, 10 zeros only, 11 detection disabled.
- retrig  input  1  0 = hold (count saturates), 1 = retrigger (count restarts after a hit).
- clr  input  1  synchronous clear of hits only.
- z  output  1  detect flag (Moore).
- State  output  2  00 IDLE, 01 ZERO (run of 0s), 10 ONE (run of 1s); 11 is unreachable.
- run_count  output  CNT_W  length of the current run, 0..RUN_LEN.
- hits  output  HIT_W  saturating count of detections.

Behaviour:
- Reset (reset=0, asynchronous): State=IDLE, run_count=0, hits=0, z=0. Outputs hold these values until the first rising edge after reset deasserts.
- Edge with en=0: State and run_count hold; hits changes only if clr=1.
- Edge with en=1:
  - IDLE: go to ZERO or ONE according to w; run_count=1.
  - w equal to the current run value, run_count<RUN_LEN: run_count+1.
  - w equal, run_count==RUN_LEN, retrig=0: hold at RUN_LEN (saturate).
  - w equal, run_count==RUN_LEN, retrig=1: run_count=1, State unchanged.
  - w differs from the current run value: switch State to ZERO/ONE per w; run_count=1.
- z is decoded combinationally from registered State, run_count and the live mode input. z=1 iff run_count==RUN_LEN and mode permits the current State.
  - mode=11, or State=IDLE, forces z=0.
  - A mode change affects z in the same cycle.
- Latency: z rises in the cycle after the edge that clocks in the RUN_LEN-th equal sample. It stays high until the next en=1 edge that alters run_count; with retrig=0 and a continuing run it stays high indefinitely.
- hits increments on an edge where run_count goes from RUN_LEN-1 to RUN_LEN and mode (sampled at that edge) permits the run's polarity.
  - Saturates at 2^HIT_W-1.
  - With retrig=0, a continued saturated run does not increment hits again.
  - clr=1 sets hits=0; clr wins over a simultaneous increment.
- reset asserted mid-run: all state clears immediately; the run restarts from IDLE after release.
- State encoding 11 must never be reached. If it is, the next edge goes to IDLE with run_count=0.

Decomposition:
- Shared package run_det_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_ZERO=2'b01, ST_ONE=2'b10;
  - mode encodings MODE_BOTH, MODE_ONES, MODE_ZEROS, MODE_OFF.
- One sub-module, sat_counter, with parameter W, inputs inc and clr, and async active-low reset; saturates at all-ones. It is instantiated for hits.
- The run counter stays inline because of its retrigger and restart logic.

Test Plan:
- Reset and simple hit: reset low 2 cycles, then en=1, mode=00, retrig=0, w=1,1,1,1 → State=10, run_count 1,2,3,4, z=1 after the 4th edge, hits=1.
- Broken run: w=1,1,1,0 → z never asserts, State=01, run_count=1, hits=0.
- Mode filter: mode=01, w=0,0,0,0 → State=01, run_count=4, z=0, hits=0. Then switch mode to 00 with no clock edge → z=1 in the same cycle.
- Retrigger: retrig=1, w=1 for 8 samples → run_count 1..4,1..4; z high after the 4th and after the 8th edge; hits=2. Repeat with retrig=0 → run_count holds 4, z high from the 4th edge onward, hits=1.
- Enable gating and clr: w=0,0 with en=1, then 3 cycles en=0 with w toggling, then w=0,0 with en=1 → hit on the 4th enabled sample. Assert clr on that same edge → hits=0.
- Saturation and reset mid-run: HIT_W=2, retrig=1, 16 ones → hits=3, saturated. Then pulse reset low mid-run after 2 samples → State=00, run_count=0, z=0, hits=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared encodings and helpers for the run detector.
// The state and mode codes drive board LEDs directly, so their values are fixed.
package run_det_pkg;

   // Run state: which polarity the current run is made of.
   // ST_BAD is never entered in normal operation.
   // It is named so that the FSM can recover from it explicitly.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ZERO = 2'b01,
      ST_ONE  = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   // Detection polarity filter applied to the z flag and to hit counting.
   typedef enum logic [1:0] {
      MODE_BOTH  = 2'b00,
      MODE_ONES  = 2'b01,
      MODE_ZEROS = 2'b10,
      MODE_OFF   = 2'b11
   } mode_t;

   // Returns 1 when the given mode allows reporting a run held in the given state.
   // IDLE and the unreachable code never qualify, whatever the mode.
   function automatic logic mode_permits(input state_t st, input mode_t md);
      logic allow;
      allow = 1'b0;
      case (md)
         MODE_BOTH:  allow = (st == ST_ZERO) || (st == ST_ONE);
         MODE_ONES:  allow = (st == ST_ONE);
         MODE_ZEROS: allow = (st == ST_ZERO);
         default:    allow = 1'b0;
      endcase
      return allow;
   endfunction

   // Maps a sample value to the run state that a run of that value occupies.
   function automatic state_t polarity_state(input logic sample);
      return sample ? ST_ONE : ST_ZERO;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear and an asynchronous active-low reset.
// When clear and increment arrive on the same edge, the clear takes effect.
// Once the count reaches all-ones it stays there until it is cleared.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] LP_MAX = {W{1'b1}};
   localparam logic [W-1:0] LP_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_count;

   // Count register: reset, then clear, then increment unless already at the ceiling.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != LP_MAX)) begin
         r_count <= r_count + LP_ONE;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/run_detector.sv
// Run detector: flags RUN_LEN consecutive equal samples on w.
// The detection can be filtered by polarity (mode).
// A full-length run either holds (saturates) or restarts (retrig).
// Each qualifying completion of a run is counted in the saturating hits counter.
module run_detector
   import run_det_pkg::*;
#(
   parameter int RUN_LEN = 4,
   parameter int CNT_W   = $clog2(RUN_LEN + 1),
   parameter int HIT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             w,
   input  logic [1:0]       mode,
   input  logic             retrig,
   input  logic             clr,
   output logic             z,
   output logic [1:0]       State,
   output logic [CNT_W-1:0] run_count,
   output logic [HIT_W-1:0] hits
);

   localparam logic [CNT_W-1:0] LP_FULL   = CNT_W'(RUN_LEN);
   localparam logic [CNT_W-1:0] LP_PENULT = CNT_W'(RUN_LEN - 1);
   localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_run_count;

   state_t           w_next_state;
   logic [CNT_W-1:0] w_next_count;
   logic             w_hit_inc;
   logic             w_run_bit;
   logic             w_same;
   mode_t            w_mode;

   assign w_mode    = mode_t'(mode);
   assign w_run_bit = (r_state == ST_ONE);
   assign w_same    = (w == w_run_bit);

   // State and run-length registers.
   // Both clear at once when reset is asserted, without waiting for a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_run_count <= '0;
      end else begin
         r_state     <= w_next_state;
         r_run_count <= w_next_count;
      end
   end

   // Next state and run length.
   // This block also produces the one-edge pulse that bumps hits.
   // That pulse fires only on the RUN_LEN-1 -> RUN_LEN step, so a held, saturated run is counted once.
   // The unreachable state code is recovered to IDLE on any edge, enabled or not.
   always_comb begin
      w_next_state = r_state;
      w_next_count = r_run_count;
      w_hit_inc    = 1'b0;
      if (r_state == ST_BAD) begin
         w_next_state = ST_IDLE;
         w_next_count = '0;
      end else if (en) begin
         if (r_state == ST_IDLE) begin
            w_next_state = polarity_state(w);
            w_next_count = LP_ONE;
         end else if (w_same) begin
            if (r_run_count < LP_FULL) begin
               w_next_count = r_run_count + LP_ONE;
               if ((r_run_count == LP_PENULT) && mode_permits(r_state, w_mode)) begin
                  w_hit_inc = 1'b1;
               end
            end else if (retrig) begin
               w_next_count = LP_ONE;
            end
         end else begin
            w_next_state = polarity_state(w);
            w_next_count = LP_ONE;
         end
      end
   end

   // Hit counter.
   // A clear on the same edge as a completing run leaves hits at zero.
   sat_counter #(
      .W(HIT_W)
   ) u_hits (
      .clk  (clk),
      .reset(reset),
      .inc  (w_hit_inc),
      .clr  (clr),
      .count(hits)
   );

   // Moore detect flag.
   // It is decoded from the registered run and the live mode, so a mode change shows up without a clock edge.
   always_comb begin
      z = (r_run_count == LP_FULL) && mode_permits(r_state, w_mode);
   end

   assign State     = r_state;
   assign run_count = r_run_count;

endmodule

// File: tb/tb_run_detector.sv
// Directed testbench for run_detector.
// uDut uses the default parameters.
// uSat shares every input but has a 2-bit hit counter, so it can show hits saturating.
module tb_run_detector;

   logic       clk;
   logic       reset;
   logic       en;
   logic       w;
   logic [1:0] mode;
   logic       retrig;
   logic       clr;

   logic       zDut;
   logic [1:0] stateDut;
   logic [2:0] countDut;
   logic [7:0] hitsDut;

   logic       zSat;
   logic [1:0] stateSat;
   logic [2:0] countSat;
   logic [1:0] hitsSat;

   int checkCount = 0;
   int passCount  = 0;

   run_detector #(.RUN_LEN(4), .HIT_W(8)) uDut (
      .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .retrig(retrig), .clr(clr),
      .z(zDut), .State(stateDut), .run_count(countDut), .hits(hitsDut)
   );

   run_detector #(.RUN_LEN(4), .HIT_W(2)) uSat (
      .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .retrig(retrig), .clr(clr),
      .z(zSat), .State(stateSat), .run_count(countSat), .hits(hitsSat)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one sample and let it be clocked in.
   // Outputs are then stable 1 unit after the edge.
   task automatic applyStimulus(input logic wBit);
      w = wBit;
      @(posedge clk);
      #1;
   endtask

   // Short asynchronous reset pulse between scenarios.
   task automatic pulseReset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b0; w = 1'b0; mode = 2'b00; retrig = 1'b0; clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkCount++;
      if (stateDut !== 2'b00) $display("[TB] FAIL reset_state: got %0b expected 00", stateDut);
      else passCount++;
      checkCount++;
      if (countDut !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", countDut);
      else passCount++;
      checkCount++;
      if (zDut !== 1'b0) $display("[TB] FAIL reset_z: got %0b expected 0", zDut);
      else passCount++;
      checkCount++;
      if (hitsDut !== 8'd0) $display("[TB] FAIL reset_hits: got %0d expected 0", hitsDut);
      else passCount++;
      reset = 1'b1;
   endtask

   task automatic test_simple_hit();
      en = 1'b1; mode = 2'b00; retrig = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1);
         checkCount++;
         if (countDut !== 3'(i)) $display("[TB] FAIL simple_count%0d: got %0d expected %0d", i, countDut, i);
         else passCount++;
         checkCount++;
         if (zDut !== (i == 4)) $display("[TB] FAIL simple_z%0d: got %0b expected %0b", i, zDut, (i == 4));
         else passCount++;
      end
      checkCount++;
      if (stateDut !== 2'b10) $display("[TB] FAIL simple_state: got %0b expected 10", stateDut);
      else passCount++;
      checkCount++;
      if (hitsDut !== 8'd1) $display("[TB] FAIL simple_hits: got %0d expected 1", hitsDut);
      else passCount++;
   endtask

   task automatic test_broken_run();
      logic [3:0] pattern;
      pulseReset();
      pattern = 4'b0111;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(pattern[i]);
         checkCount++;
         if (zDut !== 1'b0) $display("[TB] FAIL broken_z%0d: got %0b expected 0", i, zDut);
         else passCount++;
      end
      checkCount++;
      if (stateDut !== 2'b01) $display("[TB] FAIL broken_state: got %0b expected 01", stateDut);
      else passCount++;
      checkCount++;
      if (countDut !== 3'd1) $display("[TB] FAIL broken_count: got %0d expected 1", countDut);
      else passCount++;
      checkCount++;
      if (hitsDut !== 8'd0) $display("[TB] FAIL broken_hits: got %0d expected 0", hitsDut);
      else passCount++;
   endtask

   task automatic test_mode_filter();
      pulseReset();
      mode = 2'b01;
      repeat (4) applyStimulus(1'b0);
      checkCount++;
      if (stateDut !== 2'b01) $display("[TB] FAIL mode_state: got %0b expected 01", stateDut);
      else passCount++;
      checkCount++;
      if (countDut !== 3'd4) $display("[TB] FAIL mode_count: got %0d expected 4", countDut);
      else passCount++;
      checkCount++;
      if (zDut !== 1'b0) $display("[TB] FAIL mode_ones_z: got %0b expected 0", zDut);
      else passCount++;
      checkCount++;
      if (hitsDut !== 8'd0) $display("[TB] FAIL mode_hits: got %0d expected 0", hitsDut);
      else passCount++;
      // Mode changes without any clock edge.
      mode = 2'b00;
      #1;
      checkCount++;
      if (zDut !== 1'b1) $display("[TB] FAIL mode_both_z: got %0b expected 1", zDut);
      else passCount++;
      mode = 2'b10;
      #1;
      checkCount++;
      if (zDut !== 1'b1) $display("[TB] FAIL mode_zeros_z: got %0b expected 1", zDut);
      else passCount++;
      mode = 2'b11;
      #1;
      checkCount++;
      if (zDut !== 1'b0) $display("[TB] FAIL mode_off_z: got %0b expected 0", zDut);
      else passCount++;
      // A held, saturated run does not count a hit even once the mode allows it.
      mode = 2'b00;
      applyStimulus(1'b0);
      checkCount++;
      if (hitsDut !== 8'd0) $display("[TB] FAIL mode_hold_hits: got %0d expected 0", hitsDut);
      else passCount++;
   endtask

   task automatic test_retrigger();
      int expCount;
      pulseReset();
      mode = 2'b00; retrig = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1);
         expCount = ((i - 1) % 4) + 1;
         checkCount++;
         if (countDut !== 3'(expCount)) $display("[TB] FAIL retrig_count%0d: got %0d expected %0d", i, countDut, expCount);
         else passCount++;
         checkCount++;
         if (zDut !== (expCount == 4)) $display("[TB] FAIL retrig_z%0d: got %0b expected %0b", i, zDut, (expCount == 4));
         else passCount++;
      end
      checkCount++;
      if (hitsDut !== 8'd2) $display("[TB] FAIL retrig_hits: got %0d expected 2", hitsDut);
      else passCount++;
      pulseReset();
      retrig = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1);
         expCount = (i < 4) ? i : 4;
         checkCount++;
         if (countDut !== 3'(expCount)) $display("[TB] FAIL hold_count%0d: got %0d expected %0d", i, countDut, expCount);
         else passCount++;
         checkCount++;
         if (zDut !== (i >= 4)) $display("[TB] FAIL hold_z%0d: got %0b expected %0b", i, zDut, (i >= 4));
         else passCount++;
      end
      checkCount++;
      if (hitsDut !== 8'd1) $display("[TB] FAIL hold_hits: got %0d expected 1", hitsDut);
      else passCount++;
   endtask

   task automatic test_enable_clr();
      logic [2:0] toggles;
      pulseReset();
      mode = 2'b00; retrig = 1'b0; en = 1'b1;
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      en = 1'b0;
      toggles = 3'b101;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(toggles[i]);
         checkCount++;
         if (countDut !== 3'd2) $display("[TB] FAIL gate_count%0d: got %0d expected 2", i, countDut);
         else passCount++;
         checkCount++;
         if (stateDut !== 2'b01) $display("[TB] FAIL gate_state%0d: got %0b expected 01", i, stateDut);
         else passCount++;
      end
      en = 1'b1;
      applyStimulus(1'b0);
      checkCount++;
      if (countDut !== 3'd3) $display("[TB] FAIL gate_count3: got %0d expected 3", countDut);
      else passCount++;
      clr = 1'b1;
      applyStimulus(1'b0);
      clr = 1'b0;
      checkCount++;
      if (countDut !== 3'd4) $display("[TB] FAIL gate_count4: got %0d expected 4", countDut);
      else passCount++;
      checkCount++;
      if (zDut !== 1'b1) $display("[TB] FAIL gate_z: got %0b expected 1", zDut);
      else passCount++;
      checkCount++;
      if (hitsDut !== 8'd0) $display("[TB] FAIL clr_wins_hits: got %0d expected 0", hitsDut);
      else passCount++;
   endtask

   task automatic test_saturation_reset();
      pulseReset();
      mode = 2'b00; retrig = 1'b1; en = 1'b1; clr = 1'b0;
      repeat (16) applyStimulus(1'b1);
      checkCount++;
      if (hitsSat !== 2'd3) $display("[TB] FAIL sat_hits: got %0d expected 3", hitsSat);
      else passCount++;
      checkCount++;
      if (hitsDut !== 8'd4) $display("[TB] FAIL wide_hits: got %0d expected 4", hitsDut);
      else passCount++;
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkCount++;
      if (countDut !== 3'd2) $display("[TB] FAIL midrun_count: got %0d expected 2", countDut);
      else passCount++;
      // Reset is applied between clock edges; outputs must clear immediately.
      reset = 1'b0;
      #2;
      checkCount++;
      if (stateDut !== 2'b00) $display("[TB] FAIL async_state: got %0b expected 00", stateDut);
      else passCount++;
      checkCount++;
      if (countDut !== 3'd0) $display("[TB] FAIL async_count: got %0d expected 0", countDut);
      else passCount++;
      checkCount++;
      if (zDut !== 1'b0) $display("[TB] FAIL async_z: got %0b expected 0", zDut);
      else passCount++;
      checkCount++;
      if (hitsDut !== 8'd0) $display("[TB] FAIL async_hits: got %0d expected 0", hitsDut);
      else passCount++;
      checkCount++;
      if (hitsSat !== 2'd0) $display("[TB] FAIL async_sat_hits: got %0d expected 0", hitsSat);
      else passCount++;
      reset = 1'b1;
      applyStimulus(1'b1);
      checkCount++;
      if (stateDut !== 2'b10) $display("[TB] FAIL restart_state: got %0b expected 10", stateDut);
      else passCount++;
      checkCount++;
      if (countDut !== 3'd1) $display("[TB] FAIL restart_count: got %0d expected 1", countDut);
      else passCount++;
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      test_reset();
      test_simple_hit();
      test_broken_run();
      test_mode_filter();
      test_retrigger();
      test_enable_clr();
      test_saturation_reset();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
